// File: rtl/seq_divider_21x8_pkg.sv
// Shared widths, saturation limits and FSM state type for the 21/8 sequential divider.
package div_pkg;

   localparam int DIV_DW = 21;
   localparam int DIV_VW = 8;
   localparam int DIV_QW = 13;

   localparam int QMAX = 2**(DIV_QW-1) - 1;
   localparam int QMIN = -(2**(DIV_QW-1));

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/seq_divider_21x8_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
   parameter int VW = 8
) (
   input  logic [VW-1:0] rem_i,
   input  logic [VW-1:0] divisor_i,
   input  logic          bit_i,
   output logic [VW-1:0] rem_o,
   output logic          q_bit_o
);

   logic [VW:0] shifted;

   // NOTE: every output is assigned on every path through this block, so no latch is inferred.
   always_comb begin
      shifted = {rem_i, bit_i};
      q_bit_o = (shifted >= {1'b0, divisor_i});
      // After a successful subtraction the result is below the divisor, so it fits in VW bits.
      rem_o   = q_bit_o ? VW'(shifted - {1'b0, divisor_i}) : VW'(shifted);
   end

endmodule

// File: rtl/seq_divider_21x8.sv
// Signed 21-bit by unsigned 8-bit sequential restoring divider with truncation and saturation.
module seq_divider_21x8
   import div_pkg::*;
#(
   parameter int DW = DIV_DW,
   parameter int VW = DIV_VW,
   parameter int QW = DIV_QW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic signed [DW-1:0] dividend,
   input  logic        [VW-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic signed [QW-1:0] quotient,
   output logic signed [VW:0]   remainder,
   output logic                 div_by_zero,
   output logic                 overflow
);

   localparam int CW          = $clog2(DW);
   localparam int SAT_POS     = 2**(QW-1) - 1;
   localparam int SAT_NEG_MAG = 2**(QW-1);

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic [DW-1:0]  dvd_q;
   logic [VW-1:0]  dvs_q;
   logic           neg_q;
   logic           dz_q;
   logic [VW-1:0]  rem_q;
   logic [DW-1:0]  quo_q;
   logic           done_q;
   logic [QW-1:0]  quotient_q;
   logic [VW:0]    remainder_q;
   logic           div_by_zero_q;
   logic           overflow_q;

   logic [DW-1:0]  mag_d;
   logic [VW-1:0]  step_rem_d;
   logic           step_bit_d;
   logic [VW:0]    rem_ext_d;

   // The most negative dividend wraps to itself, which read as unsigned is exactly its magnitude.
   assign mag_d     = dividend[DW-1] ? $unsigned(-dividend) : $unsigned(dividend);
   assign rem_ext_d = {1'b0, rem_q};

   div_step #(.VW(VW)) u_step (
      .rem_i     (rem_q),
      .divisor_i (dvs_q),
      .bit_i     (dvd_q[DW-1]),
      .rem_o     (step_rem_d),
      .q_bit_o   (step_bit_d)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the datapath registers are reset too, so an aborted operation leaves nothing behind.
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         dvd_q         <= '0;
         dvs_q         <= '0;
         neg_q         <= 1'b0;
         dz_q          <= 1'b0;
         rem_q         <= '0;
         quo_q         <= '0;
         done_q        <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     dz_q    <= 1'b1;
                     state_q <= S_FIX;
                  end else begin
                     dz_q    <= 1'b0;
                     dvd_q   <= mag_d;
                     dvs_q   <= divisor;
                     neg_q   <= dividend[DW-1];
                     cnt_q   <= CW'(DW-1);
                     rem_q   <= '0;
                     quo_q   <= '0;
                     state_q <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               dvd_q <= {dvd_q[DW-2:0], 1'b0};
               rem_q <= step_rem_d;
               quo_q <= {quo_q[DW-2:0], step_bit_d};
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) state_q <= S_FIX;
            end
            S_FIX: begin
               if (dz_q) begin
                  quotient_q    <= '0;
                  remainder_q   <= '0;
                  div_by_zero_q <= 1'b1;
                  overflow_q    <= 1'b0;
               end else begin
                  div_by_zero_q <= 1'b0;
                  remainder_q   <= neg_q ? (VW+1)'(0) - rem_ext_d : rem_ext_d;
                  if (!neg_q) begin
                     overflow_q <= (quo_q > DW'(SAT_POS));
                     quotient_q <= (quo_q > DW'(SAT_POS)) ? QW'(SAT_POS) : quo_q[QW-1:0];
                  end else begin
                     overflow_q <= (quo_q > DW'(SAT_NEG_MAG));
                     quotient_q <= (quo_q > DW'(SAT_NEG_MAG)) ? QW'(SAT_NEG_MAG)
                                                              : QW'(0) - quo_q[QW-1:0];
                  end
               end
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_divider_21x8.sv
// Self-checking bench for seq_divider_21x8: directed corner cases plus random operands vs. an arithmetic model.
module tb_seq_divider_21x8;
   import div_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic signed [20:0] dividend = '0;
   logic        [7:0]  divisor = '0;
   logic               busy, done, div_by_zero, overflow;
   logic signed [12:0] quotient;
   logic signed [8:0]  remainder;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   seq_divider_21x8 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain integer arithmetic: truncating division, remainder takes the dividend sign.
   function automatic void model(input int a, input int b, output int q, output int r,
                                 output bit dz, output bit ov);
      int qt;
      if (b == 0) begin
         q = 0; r = 0; dz = 1'b1; ov = 1'b0;
      end else begin
         qt = a / b;
         r  = a % b;
         dz = 1'b0;
         ov = (qt > QMAX) || (qt < QMIN);
         q  = (qt > QMAX) ? QMAX : (qt < QMIN) ? QMIN : qt;
      end
   endfunction

   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic run_op(input logic signed [20:0] a, input logic [7:0] b, input string tag);
      int q, r, lat;
      bit dz, ov;
      model(a, int'(b), q, r, dz, ov);
      start = 1'b1; dividend = a; divisor = b;
      tick();
      start = 1'b0;
      check({tag, " busy"}, busy, 1);
      wait_done(lat);
      check({tag, " latency"}, lat, (b == 0) ? 1 : 22);
      check({tag, " quotient"}, quotient, q);
      check({tag, " remainder"}, remainder, r);
      check({tag, " div_by_zero"}, div_by_zero, dz);
      check({tag, " overflow"}, overflow, ov);
      check({tag, " idle"}, busy, 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " quotient"}, quotient, 0);
      check({tag, " remainder"}, remainder, 0);
      check({tag, " div_by_zero"}, div_by_zero, 0);
      check({tag, " overflow"}, overflow, 0);
   endtask

   initial begin
      int lat, seen;
      logic signed [20:0] ra;
      logic        [7:0]  rb;

      #3;
      check_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_op(21'sd1000, 8'd7, "1000/7");
      run_op(-21'sd1000, 8'd7, "-1000/7");

      // Abort a calculation with reset partway through.
      start = 1'b1; dividend = 21'sd1000; divisor = 8'd7;
      tick();
      start = 1'b0;
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("mid reset");
      seen = 0;
      repeat (3) begin
         tick();
         if (done === 1'b1) seen++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) begin
         tick();
         if (done === 1'b1) seen++;
      end
      check("aborted no done", seen, 0);
      run_op(21'sd1000, 8'd7, "after reset");

      run_op(21'sd1048575, 8'd1, "max/1");
      run_op(-21'sd1048576, 8'd255, "min/255");
      run_op(-21'sd1048576, 8'd1, "min/1");
      run_op(21'sd4095, 8'd1, "4095/1");
      run_op(21'sd4096, 8'd1, "4096/1");
      run_op(-21'sd4096, 8'd1, "-4096/1");
      run_op(-21'sd4097, 8'd1, "-4097/1");
      run_op(21'sd500, 8'd0, "500/0");
      run_op(21'sd0, 8'd5, "0/5");
      run_op(-21'sd1, 8'd255, "-1/255");

      // A start while busy is ignored; a start during the done cycle is accepted.
      start = 1'b1; dividend = 21'sd100; divisor = 8'd3;
      tick();
      start = 1'b0;
      repeat (4) tick();
      start = 1'b1; dividend = 21'sd9; divisor = 8'd9;
      tick();
      start = 1'b0;
      wait_done(lat);
      check("ignored start latency", lat, 17);
      check("ignored start quotient", quotient, 33);
      check("ignored start remainder", remainder, 1);
      run_op(21'sd9, 8'd9, "done-cycle start");
      repeat (3) tick();
      check("hold done", done, 0);
      check("hold quotient", quotient, 1);
      check("hold remainder", remainder, 0);

      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) ra = 21'($urandom);
         else            ra = 21'($urandom_range(0, 60000)) - 21'sd30000;
         rb = 8'($urandom_range(0, 255));
         run_op(ra, rb, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
